acc_ctrl: RTL and testbench
===========================

ACC_CTRL -- requirements
Module: acc_ctrl

Interface
REQ-001 SHALL have parameter: LEN_W, 8, width of operand count.
REQ-002 SHALL have parameter: ADDR_W, 8, width of operand read address.
REQ-003 SHALL have port: clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port: rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: start_i  input  1  request a new accumulation; sampled only in IDLE.
REQ-006 SHALL have port: len_i  input  LEN_W  number of operands to accumulate; latched on accepted start.
REQ-007 SHALL have port: base_addr_i  input  ADDR_W  first operand address; latched on accepted start.
REQ-008 SHALL have port: data_valid_i  input  1  operand at rd_addr_o is present on the accumulator input this cycle.
REQ-009 SHALL have port: rd_en_o  output  1  operand fetch request.
REQ-010 SHALL have port: rd_addr_o  output  ADDR_W  operand fetch address.
REQ-011 SHALL have port: acc_clr_o  output  1  clear strobe to the accumulator register.
REQ-012 SHALL have port: acc_en_o  output  1  load enable to the accumulator register.
REQ-013 SHALL have port: busy_o  output  1  high in every state except IDLE.
REQ-014 SHALL have port: done_o  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, CLR, RUN, DONE, encoded in one registered state variable.
REQ-016 IDLE: start_i=1 -> latch len_i, base_addr_i, zero index counter, go CLR; start_i ignored in all other states.
REQ-017 CLR: acc_clr_o=1 for exactly one cycle; next state RUN if latched len!=0, else DONE.
REQ-018 RUN: rd_en_o=1, rd_addr_o=base+index modulo 2^ADDR_W (wrap-around, no error).
REQ-019 RUN: acc_en_o=data_valid_i combinationally in the same cycle; acc_en_o=0 in every other state.
REQ-020 RUN: each cycle with data_valid_i=1 increments index; on the cycle index==len-1 with data_valid_i=1 -> DONE.
REQ-021 RUN: data_valid_i=0 stalls with rd_addr_o held; no timeout.
REQ-022 DONE: done_o=1 for one cycle, then IDLE; start_i in DONE not accepted, earliest restart is the following cycle.
REQ-023 Latency: len=N with data_valid_i always high -> done_o asserted N+2 cycles after the start_i cycle.
REQ-024 acc_clr_o and acc_en_o SHALL never be high in the same cycle.
REQ-025 len_i/base_addr_i changes after acceptance SHALL have no effect on the running job.

Reset
REQ-026 rstn=0 at posedge SHALL force IDLE, index=0, latched len/base=0, from any state including mid-RUN.
REQ-027 Reset values: rd_en_o=0, rd_addr_o=0, acc_clr_o=0, acc_en_o=0, busy_o=0, done_o=0 (plus irq_o=0 when compiled in).
REQ-028 Reset SHALL NOT generate an acc_clr_o pulse; the accumulator register has its own reset.

Configuration
REQ-029 Macro ACC_CTRL_IRQ_EN defined: ports irq_o (output 1, sticky, set on done_o) and irq_clr_i (input 1) exist; irq_clr_i=1 clears irq_o next cycle; set wins over simultaneous clear.
REQ-030 ACC_CTRL_IRQ_EN undefined: irq_o, irq_clr_i and related logic absent; all other behaviour identical.

Structure
REQ-031 Shared package SHALL hold the FSM state typedef/localparams (IDLE, CLR, RUN, DONE) and default LEN_W/ADDR_W constants.
REQ-032 One sub-module acc_ctrl_cnt SHALL hold the index counter with latched len, providing last-operand flag and rd_addr_o; the FSM stays in acc_ctrl.

Verification
REQ-033 start with len=4, base=0x10, data_valid_i=1 -> acc_clr_o 1 cycle, rd_addr_o 0x10..0x13, 4 acc_en_o cycles, done_o 6 cycles after start.
REQ-034 len=0 -> CLR then DONE, zero acc_en_o cycles, done_o 2 cycles after start.
REQ-035 len=3, base=0xFE -> rd_addr_o 0xFE, 0xFF, 0x00.
REQ-036 len=5, data_valid_i toggling 1,0,0,1,... -> acc_en_o exactly 5 times, address held during stalls, start_i pulses while busy ignored.
REQ-037 rstn=0 in RUN after 2 of 5 operands -> next cycle IDLE, all outputs 0, no acc_clr_o; new start runs normally.
REQ-038 With ACC_CTRL_IRQ_EN: irq_o rises with done_o, stays high, clears one cycle after irq_clr_i; irq_clr_i coincident with done_o leaves irq_o=1.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// ============================================================================
// Module   : acc_ctrl_pkg
// Purpose  : Shared FSM state encoding and default widths for acc_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_ctrl_pkg;

  localparam int unsigned LEN_W_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/acc_ctrl_if.sv
// ============================================================================
// Module   : acc_ctrl_if
// Purpose  : Job request / operand fetch / accumulator control bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface acc_ctrl_if
  import acc_ctrl_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic              data_valid_i;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              acc_clr_o;
  logic              acc_en_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output start_i, len_i, base_addr_i, data_valid_i,
    input  rd_en_o, rd_addr_o, acc_clr_o, acc_en_o, busy_o, done_o
  );

  modport slave (
    input  start_i, len_i, base_addr_i, data_valid_i,
    output rd_en_o, rd_addr_o, acc_clr_o, acc_en_o, busy_o, done_o
  );

endinterface

`default_nettype wire

// File: rtl/acc_ctrl_cnt.sv
// ============================================================================
// Module   : acc_ctrl_cnt
// Purpose  : Operand index counter with latched length/base; last flag + address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_ctrl_cnt
  import acc_ctrl_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic              last_o,
  output logic              len_zero_o,
  output logic [ADDR_W-1:0] rd_addr_o
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [LEN_W-1:0]  idx_q,  idx_d;
  logic [LEN_W-1:0]  len_q,  len_d;
  logic [ADDR_W-1:0] base_q, base_d;

  always_comb begin
    idx_d  = idx_q;
    len_d  = len_q;
    base_d = base_q;
    if (load_i) begin
      idx_d  = '0;
      len_d  = len_i;
      base_d = base_i;
    end else if (inc_i) begin
      idx_d  = idx_q + LEN_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_q  <= '0;
      len_q  <= '0;
      base_q <= '0;
    end else begin
      idx_q  <= idx_d;
      len_q  <= len_d;
      base_q <= base_d;
    end
  end

  // Only meaningful while len_q != 0; the FSM never enters RUN otherwise.
  assign last_o     = (idx_q == (len_q - LEN_ONE));
  assign len_zero_o = (len_q == '0);
  assign rd_addr_o  = base_q + ADDR_W'(idx_q);

endmodule

`default_nettype wire

// File: rtl/acc_ctrl.sv
// ============================================================================
// Module   : acc_ctrl
// Purpose  : Accumulation job sequencer (IDLE/CLR/RUN/DONE) driving operand
//            fetch and accumulator clear/enable. Optional sticky interrupt
//            when ACC_CTRL_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  acc_ctrl_if.slave  bus
`ifdef ACC_CTRL_IRQ_EN
  ,
  input  logic       irq_clr_i,
  output logic       irq_o
`endif
);

  state_e            state_q, state_d;
  logic              load;
  logic              inc;
  logic              last;
  logic              len_zero;
  logic [ADDR_W-1:0] rd_addr;

  acc_ctrl_cnt #(
    .LEN_W  (LEN_W),
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (load),
    .inc_i      (inc),
    .len_i      (bus.len_i),
    .base_i     (bus.base_addr_i),
    .last_o     (last),
    .len_zero_o (len_zero),
    .rd_addr_o  (rd_addr)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          load    = 1'b1;
          state_d = CLR;
        end
      end
      CLR: begin
        state_d = len_zero ? DONE : RUN;
      end
      RUN: begin
        if (bus.data_valid_i) begin
          inc = 1'b1;
          if (last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs from state; acc_en follows data_valid in the same cycle.
  assign bus.rd_en_o   = (state_q == RUN);
  assign bus.rd_addr_o = rd_addr;
  assign bus.acc_clr_o = (state_q == CLR);
  assign bus.acc_en_o  = (state_q == RUN) && bus.data_valid_i;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = (state_q == DONE);

`ifdef ACC_CTRL_IRQ_EN
  logic irq_q, irq_d;

  // Completion has priority over a coincident clear so no event is lost.
  always_comb begin
    irq_d = irq_q;
    if (state_q == DONE) begin
      irq_d = 1'b1;
    end else if (irq_clr_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_acc_ctrl.sv
// ============================================================================
// Module   : tb_acc_ctrl
// Purpose  : Self-checking bench for acc_ctrl: directed table, job scenarios,
//            reset mid-job, optional ACC_CTRL_IRQ_EN checks, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_ctrl;

  localparam int LEN_W  = 8;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rstn;
  logic irq_clr;
`ifdef ACC_CTRL_IRQ_EN
  logic irq;
`endif

  always #5 clk = ~clk;

  acc_ctrl_if #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus ();

  acc_ctrl #(
    .LEN_W  (LEN_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus)
`ifdef ACC_CTRL_IRQ_EN
    ,
    .irq_clr_i (irq_clr),
    .irq_o     (irq)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Job-level reference: cycles since acceptance and operands consumed.
  bit m_busy  = 1'b0;
  int m_t     = 0;
  int m_len   = 0;
  int m_base  = 0;
  int m_taken = 0;
  bit m_irq   = 1'b0;

  int acc_addrs[$];

  function automatic bit exp_clr();
    return m_busy && (m_t == 1);
  endfunction

  function automatic bit exp_run();
    return m_busy && (m_t >= 2) && (m_taken < m_len);
  endfunction

  function automatic bit exp_done();
    return m_busy && (m_t >= 2) && (m_taken == m_len);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("acc_clr", 32'(bus.acc_clr_o), 32'(exp_clr()));
    chk("rd_en",   32'(bus.rd_en_o),   32'(exp_run()));
    chk("acc_en",  32'(bus.acc_en_o),  32'(exp_run() && bus.data_valid_i));
    chk("busy",    32'(bus.busy_o),    32'(m_busy));
    chk("done",    32'(bus.done_o),    32'(exp_done()));
    chk("clr_en_excl", 32'(bus.acc_clr_o & bus.acc_en_o), 32'd0);
    if (exp_run()) chk("rd_addr", 32'(bus.rd_addr_o), 32'((m_base + m_taken) % 256));
`ifdef ACC_CTRL_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic drive(bit st, int len, int base, bit dv, bit clr, bit rn);
    @(negedge clk);
    bus.start_i      = st;
    bus.len_i        = LEN_W'(len);
    bus.base_addr_i  = ADDR_W'(base);
    bus.data_valid_i = dv;
    irq_clr          = clr;
    rstn             = rn;
    #1;
    check_model();
  endtask

  task automatic tick();
    bit run_now, done_now;
    run_now  = exp_run();
    done_now = exp_done();
    @(posedge clk);
    if (!rstn) begin
      m_busy = 0; m_t = 0; m_len = 0; m_base = 0; m_taken = 0; m_irq = 0;
    end else begin
      if (done_now) m_irq = 1'b1;
      else if (irq_clr) m_irq = 1'b0;
      if (!m_busy) begin
        if (bus.start_i) begin
          m_busy = 1; m_t = 1; m_taken = 0;
          m_len  = int'(bus.len_i);
          m_base = int'(bus.base_addr_i);
        end
      end else if (done_now) begin
        m_busy = 0;
      end else begin
        if (run_now && bus.data_valid_i) m_taken++;
        m_t++;
      end
    end
  endtask

  // mode 0: data always valid, 1: valid every third cycle, 2: random valid
  task automatic run_job(int len, int base, int mode, bit noise,
                         output int done_off, output int n_en);
    bit dv, st;
    done_off = -1;
    n_en     = 0;
    acc_addrs.delete();
    for (int i = 0; i < 200; i++) begin
      dv = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 3 == 0) : ($urandom_range(0, 3) != 0);
      st = (i == 0) ? 1'b1 : (noise ? ($urandom_range(0, 1) == 1) : 1'b0);
      drive(st, (i == 0 || !noise) ? len : int'($urandom_range(0, 255)),
            (i == 0 || !noise) ? base : int'($urandom_range(0, 255)), dv, 1'b0, 1'b1);
      if (bus.acc_en_o === 1'b1) begin
        n_en++;
        acc_addrs.push_back(int'(bus.rd_addr_o));
      end
      if (bus.done_o === 1'b1) done_off = i;
      tick();
      if (done_off >= 0) break;
    end
    if (done_off < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL job_timeout len=%0d: got no done_o required done_o within 200 cycles", len);
    end
  endtask

  typedef struct {
    int st, len, base, dv;
    int e_clr, e_rden, e_en, e_busy, e_done, e_addr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int doff, nen;

    // len=4 base=0x10; len/base inputs change after acceptance; starts while busy ignored
    tbl[0] = '{1, 4, 'h10, 1,  0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 7, 'h55, 1,  1, 0, 0, 1, 0, 0};
    tbl[2] = '{1, 7, 'h55, 1,  0, 1, 1, 1, 0, 'h10};
    tbl[3] = '{0, 2, 'h99, 1,  0, 1, 1, 1, 0, 'h11};
    tbl[4] = '{1, 2, 'h99, 1,  0, 1, 1, 1, 0, 'h12};
    tbl[5] = '{0, 2, 'h99, 1,  0, 1, 1, 1, 0, 'h13};
    tbl[6] = '{1, 9, 'h01, 1,  0, 0, 0, 1, 1, 0};
    tbl[7] = '{0, 9, 'h01, 1,  0, 0, 0, 0, 0, 0};

    bus.start_i = 0; bus.len_i = '0; bus.base_addr_i = '0; bus.data_valid_i = 0;
    irq_clr = 0;
    rstn = 0;
    repeat (2) @(posedge clk);

    // Reset state
    drive(0, 0, 0, 1, 0, 0);
    chk("reset_rd_addr", 32'(bus.rd_addr_o), 32'd0);
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].st[0], tbl[i].len, tbl[i].base, tbl[i].dv[0], 1'b0, 1'b1);
      chk($sformatf("tbl%0d_clr", i),  32'(bus.acc_clr_o), 32'(tbl[i].e_clr));
      chk($sformatf("tbl%0d_rden", i), 32'(bus.rd_en_o),   32'(tbl[i].e_rden));
      chk($sformatf("tbl%0d_en", i),   32'(bus.acc_en_o),  32'(tbl[i].e_en));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy_o),    32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i), 32'(bus.done_o),    32'(tbl[i].e_done));
      if (tbl[i].e_rden != 0)
        chk($sformatf("tbl%0d_addr", i), 32'(bus.rd_addr_o), 32'(tbl[i].e_addr));
      tick();
    end

    run_job(4, 'h10, 0, 1'b0, doff, nen);
    chk("len4_done_latency", 32'(doff), 32'd6);
    chk("len4_en_count", 32'(nen), 32'd4);

    run_job(0, 'h33, 0, 1'b0, doff, nen);
    chk("len0_done_latency", 32'(doff), 32'd2);
    chk("len0_en_count", 32'(nen), 32'd0);

    run_job(3, 'hFE, 0, 1'b0, doff, nen);
    chk("wrap_count", 32'(acc_addrs.size()), 32'd3);
    if (acc_addrs.size() == 3) begin
      chk("wrap_addr0", 32'(acc_addrs[0]), 32'hFE);
      chk("wrap_addr1", 32'(acc_addrs[1]), 32'hFF);
      chk("wrap_addr2", 32'(acc_addrs[2]), 32'h00);
    end

    run_job(5, 'h80, 1, 1'b1, doff, nen);
    chk("stall_en_count", 32'(nen), 32'd5);

    // Reset in RUN after two of five operands
    drive(1, 5, 'h20, 1, 0, 1); tick();
    drive(0, 5, 'h20, 1, 0, 1); tick();
    drive(0, 5, 'h20, 1, 0, 1); tick();
    drive(0, 5, 'h20, 1, 0, 1); tick();
    drive(0, 5, 'h20, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 1);
    chk("rst_busy",    32'(bus.busy_o),    32'd0);
    chk("rst_clr",     32'(bus.acc_clr_o), 32'd0);
    chk("rst_rden",    32'(bus.rd_en_o),   32'd0);
    chk("rst_en",      32'(bus.acc_en_o),  32'd0);
    chk("rst_done",    32'(bus.done_o),    32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr_o), 32'd0);
    tick();
    run_job(3, 'h40, 0, 1'b0, doff, nen);
    chk("post_rst_latency", 32'(doff), 32'd5);
    chk("post_rst_en_count", 32'(nen), 32'd3);

`ifdef ACC_CTRL_IRQ_EN
    drive(0, 0, 0, 0, 0, 1);
    chk("irq_sticky", 32'(irq), 32'd1);
    tick();
    drive(0, 0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 1);
    chk("irq_cleared", 32'(irq), 32'd0);
    tick();
    drive(1, 1, 'h05, 1, 0, 1); tick();
    drive(0, 1, 'h05, 1, 0, 1); tick();
    drive(0, 1, 'h05, 1, 0, 1); tick();
    drive(0, 1, 'h05, 1, 1, 1);
    chk("irq_coincident_done", 32'(bus.done_o), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    chk("irq_set_wins", 32'(irq), 32'd1);
    tick();
`endif

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, int'($urandom_range(0, 6)),
            int'($urandom_range(0, 255)), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) == 0, $urandom_range(0, 49) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
